// File: rtl/instr_issue_queue.sv
// Instruction issue queue: buffers {func, input1, input2} words and presents them one
// at a time to the controller, holding operands stable until the controller reports done.
module instr_issue_queue #(
    parameter int DEPTH  = 8,
    parameter int FUNC_W = 4,
    parameter int OPND_W = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [FUNC_W-1:0]        wr_func,
    input  logic [OPND_W-1:0]        wr_in1,
    input  logic [OPND_W-1:0]        wr_in2,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     issue_valid,
    output logic [FUNC_W-1:0]        func,
    output logic [OPND_W-1:0]        input1,
    output logic [OPND_W-1:0]        input2,
    input  logic                     issue_ack,
    input  logic                     done,
    output logic                     busy,
    output logic [1:0]               state
);

    // Handshake: issue_valid is high for the whole PRESENT state; a cycle with
    // issue_valid && issue_ack is the transfer (pop). done is honoured only in EXEC.
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = FUNC_W + 2 * OPND_W;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESENT = 2'd1;
    localparam logic [1:0] EXEC    = 2'd2;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] wr_word;
    logic [ENTRY_W-1:0] head_word;
    logic [ENTRY_W-1:0] cur_word;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   count_next;
    logic [1:0]         state_next;
    logic               load_head;
    logic               clear_fields;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = (state == PRESENT) && issue_ack;
    assign wr_word = {wr_func, wr_in1, wr_in2};

    // An empty queue finishing EXEC can still re-present if a word arrives on the
    // done edge; that word is not in storage yet, so forward it from the write port.
    assign head_word = (count == '0) ? wr_word : mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next   = state;
        load_head    = 1'b0;
        clear_fields = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = PRESENT;
                    load_head  = 1'b1;
                end
            end
            PRESENT: begin
                if (issue_ack) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (done) begin
                    if (count_next != '0) begin
                        state_next = PRESENT;
                        load_head  = 1'b1;
                    end else begin
                        state_next   = IDLE;
                        clear_fields = 1'b1;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                clear_fields = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
            cur_word <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
            cur_word <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            count <= count_next;
            state <= state_next;
            if (load_head) begin
                cur_word <= head_word;
            end else if (clear_fields) begin
                cur_word <= '0;
            end
        end
    end

    // Storage has no reset; its contents are only read where count says they are valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    assign {func, input1, input2} = cur_word;
    assign issue_valid = (state == PRESENT);
    assign busy        = (state == PRESENT) || (state == EXEC);

endmodule

// File: doc/instr_issue_queue.md
Name: instr_issue_queue

Overview:
- Buffers instruction words {func, input1, input2} written by a host or loader.
- Issues them one at a time to the control FSM (my_fsm) through a valid/ack/done handshake.
- Sits in front of the controller. It is the producer that the controller consumes from, and it holds operands stable for the full multi-cycle execution of each instruction.

Parameters:
- DEPTH, 8, number of instruction entries; power of 2, minimum 2.
- FUNC_W, 4, width of the func field.
- OPND_W, 3, width of input1 and input2.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- wr_en  input  1  push request, sampled on the clk rising edge.
- wr_func  input  FUNC_W  func field of the pushed instruction.
- wr_in1  input  OPND_W  input1 field of the pushed instruction.
- wr_in2  input  OPND_W  input2 field of the pushed instruction.
- flush  input  1  synchronous clear of queue and issue state.
- full  output  1  asserted when count == DEPTH.
- empty  output  1  asserted when count == 0.
- count  output  $clog2(DEPTH)+1  number of stored entries.
- overflow  output  1  sticky; set when wr_en is asserted while full.
- issue_valid  output  1  head instruction is presented to the controller.
- func  output  FUNC_W  func of the instruction being issued or executed.
- input1  output  OPND_W  input1 of the instruction being issued or executed.
- input2  output  OPND_W  input2 of the instruction being issued or executed.
- issue_ack  input  1  controller accepts the presented instruction.
- done  input  1  controller has finished the current instruction.
- busy  output  1  asserted in the PRESENT or EXEC state.

Behaviour:
- Reset (reset_n low, asynchronous): all of the following are 0 or cleared immediately, regardless of clk:
  - state = IDLE; read and write pointers = 0; count = 0; empty = 1; full = 0; overflow = 0.
  - issue_valid = 0; busy = 0; func, input1 and input2 = 0.
  - Storage contents are don't-care.
- Reset in the middle of an instruction abandons it; no pop occurs after reset deasserts.
- Push:
  - On the clk edge, if wr_en and !full, the instruction is stored at wr_ptr, wr_ptr increments modulo DEPTH and count increments.
  - If wr_en and full, the write is dropped and overflow is set. Full is evaluated before any same-cycle pop, so a push to a full queue is always rejected.
- State machine (registered, one transition per edge):
  - IDLE: if count > 0, go to PRESENT. issue_valid = 0 and func/input1/input2 = 0.
  - PRESENT: issue_valid = 1. func/input1/input2 are registered copies of the head entry, captured on entry and held. When issue_ack = 1: pop the head (rd_ptr + 1, count − 1) and go to EXEC.
  - EXEC: issue_valid = 0; func/input1/input2 are held unchanged. On done = 1: go to PRESENT if count after the done cycle > 0 (head captured on that edge), otherwise go to IDLE and clear the fields to 0.
- done is ignored outside EXEC. issue_ack is ignored outside PRESENT.
- A push and a pop on the same edge leave count unchanged and both pointers advance.
- Latency:
  - A push into an empty queue while in IDLE gives issue_valid = 1 two edges after the write edge (write edge, then IDLE→PRESENT edge).
  - Back-to-back issue: issue_valid reasserts on the edge after done.
- Pointers wrap modulo DEPTH with no bubble.
- flush (synchronous, higher priority than push, pop, ack and done): pointers and count = 0, state = IDLE, outputs = 0, overflow = 0.
- overflow clears only on reset or flush.

Test Plan:
- Reset, then push {0001,000,011}: count = 1, empty = 0; 2 edges later issue_valid = 1, func = 0001, input1 = 000, input2 = 011.
- ack in PRESENT, then done after 3 cycles: issue_valid = 0 during EXEC, fields held at 0001/000/011, count = 0; after done, state = IDLE and fields = 0.
- Push 4 instructions {0001,000,011}, {0001,001,101}, {0010,001,011}, {1001,000,001} while the controller acks each immediately and gives done 2 cycles later: they issue in order with no gaps beyond 1 cycle between done and issue_valid.
- Fill DEPTH = 8 entries, then push a 9th: full = 1, count = 8, overflow = 1, and the 9th entry never issues. Pop one and push again: count returns to 8, pointers wrap, and order is preserved.
- Push and pop on the same edge with count = 3: count stays 3 and the head advances.
- Assert reset_n low mid-EXEC with count = 2: all outputs go to 0 asynchronously. After release the queue is empty and the interrupted instruction is not replayed. Assert flush mid-PRESENT: next edge gives count = 0, state = IDLE, overflow = 0.
